// File: rtl/sd_wrrdemux_pkg.sv
// sd_wrrdemux_pkg: shared constants and the rotating first-match search for the WRR distributor.
//   SD_OUTPUTS  default number of producer ports
//   SD_DEST_W   dest index width for the default port count
//   SD_MAX_N    widest port vector the search function handles
//   nxt_nonzero first index at or after ptr (rotating over n ports) with weights[i] & mask[i] set;
//               returns ptr when nothing matches
package sd_wrrdemux_pkg;
    localparam int SD_OUTPUTS = 4;
    localparam int SD_DEST_W  = $clog2(SD_OUTPUTS);
    localparam int SD_MAX_N   = 32;

    function automatic int nxt_nonzero(input int ptr, input logic [SD_MAX_N-1:0] weights,
                                       input logic [SD_MAX_N-1:0] mask, input int n);
        int j;
        nxt_nonzero = ptr;
        // Walking down means the closest match to ptr is the last one written.
        for (int k = SD_MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                j = (j >= n) ? j - n : j;
                if (weights[j[4:0]] && mask[j[4:0]]) nxt_nonzero = j;
            end
        end
    endfunction
endpackage

// File: rtl/sd_wrr_rotsel.sv
// sd_wrr_rotsel: combinational rotating priority finder.
//   start  index where the search begins (inclusive)
//   nz     ports with a nonzero weight
//   mask   extra qualifier per port (all ones when only the weight matters)
//   idx    first port from start, wrapping n-1 -> 0, with nz & mask set; start if none
module sd_wrr_rotsel
    import sd_wrrdemux_pkg::*;
#(
    parameter int n  = 4,
    parameter int dw = 2
) (
    input  logic [dw-1:0] start,
    input  logic [n-1:0]  nz,
    input  logic [n-1:0]  mask,
    output logic [dw-1:0] idx
);
    always_comb idx = dw'(nxt_nonzero(int'(start), 32'(nz), 32'(mask), n));
endmodule

// File: rtl/sd_wrrdemux.sv
// sd_wrrdemux: srdy/drdy 1-to-N weighted-round-robin distributor with a one-word output stage.
//   clk, reset  clock; asynchronous active-high reset
//   c_srdy/c_drdy/c_data  consumer-side input stream
//   c_weight    per-port weight, port i at [i*weight_sz +: weight_sz]; 0 skips the port
//   p_srdy      one-hot valid toward the destination port
//   p_drdy      per-port ready
//   p_data      shared output word
//   p_dest      index of the port holding p_srdy
// Build option SD_WRRDEMUX_SKIP_EN: work-conserving target choice that passes over
// stalled ports; without it the schedule is strict.
module sd_wrrdemux
    import sd_wrrdemux_pkg::*;
#(
    parameter int width     = 8,
    parameter int outputs   = SD_OUTPUTS,
    parameter int weight_sz = 2,
    localparam int dw       = $clog2(outputs)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         c_srdy,
    output logic                         c_drdy,
    input  logic [width-1:0]             c_data,
    input  logic [outputs*weight_sz-1:0] c_weight,
    output logic [outputs-1:0]           p_srdy,
    input  logic [outputs-1:0]           p_drdy,
    output logic [width-1:0]             p_data,
    output logic [dw-1:0]                p_dest
);
    logic                 occ_q, occ_d;
    logic [width-1:0]     data_q, data_d;
    logic [dw-1:0]        dest_q, dest_d;
    logic [dw-1:0]        ptr_q, ptr_d;
    logic [weight_sz-1:0] cnt_q, cnt_d;
    logic [outputs-1:0]   nz, nz_eff;
    logic [dw-1:0]        base, tgt, adv_start, adv;
    logic [weight_sz-1:0] w_t, cnt_t;
    logic                 drain, acc, turn_end;

    always_comb begin
        nz = '0;
        for (int i = 0; i < outputs; i++) nz[i] = |c_weight[i*weight_sz +: weight_sz];
    end

    // All-zero weights degrade to plain round-robin.
    assign nz_eff = |nz ? nz : '1;

    // A ptr left on a port whose weight dropped to 0 moves on as if its turn had ended.
    assign base = dw'(nxt_nonzero(int'(ptr_q), 32'(nz_eff), '1, outputs));

`ifdef SD_WRRDEMUX_SKIP_EN
    logic [dw-1:0] rdy_pick;
    sd_wrr_rotsel #(.n(outputs), .dw(dw)) u_skip (
        .start (ptr_q),
        .nz    (nz_eff),
        .mask  (p_drdy),
        .idx   (rdy_pick)
    );
    assign tgt = |(nz_eff & p_drdy) ? rdy_pick : base;
`else
    assign tgt = base;
`endif

    assign w_t       = |nz ? c_weight[tgt*weight_sz +: weight_sz] : weight_sz'(1);
    assign cnt_t     = (tgt == ptr_q) ? cnt_q : '0;
    assign turn_end  = ({1'b0, cnt_t} + (weight_sz+1)'(1)) >= {1'b0, w_t};
    assign adv_start = (tgt == dw'(outputs - 1)) ? '0 : tgt + dw'(1);

    sd_wrr_rotsel #(.n(outputs), .dw(dw)) u_adv (
        .start (adv_start),
        .nz    (nz_eff),
        .mask  ('1),
        .idx   (adv)
    );

    assign drain  = occ_q & p_drdy[dest_q];
    assign c_drdy = ~occ_q | drain;
    assign acc    = c_srdy & c_drdy;

    always_comb begin
        occ_d  = acc | (occ_q & ~drain);
        data_d = acc ? c_data : data_q;
        dest_d = acc ? tgt : dest_q;
        ptr_d  = acc ? (turn_end ? adv : tgt) : ptr_q;
        cnt_d  = acc ? (turn_end ? '0 : cnt_t + weight_sz'(1)) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= 1'b0;
            data_q <= '0;
            dest_q <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            data_q <= data_d;
            dest_q <= dest_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign p_srdy = occ_q ? ({{(outputs-1){1'b0}}, 1'b1} << dest_q) : '0;
    assign p_data = data_q;
    assign p_dest = dest_q;
endmodule
